// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer: FSM encoding, default vectors,
// increment constant and fetch alignment helper.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;
  localparam logic [31:0] PC_INC             = 32'd4;
  localparam logic [31:0] ALIGN_MASK         = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_mux.sv
// pc_next_mux: combinational next-PC selection with redirect priority and word alignment.
// PC_SEQ_EXC_EN adds the exception input, which outranks jump and branch.
module pc_next_mux
  import pc_fetch_sequencer_pkg::*;
`ifdef PC_SEQ_EXC_EN
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
)
`endif
(
  input  logic [31:0] i_pc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_target,
`ifdef PC_SEQ_EXC_EN
  input  logic        i_exc,
`endif
  output logic [31:0] o_pc_seq,
  output logic        o_redirect,
  output logic [31:0] o_target
);

  logic [31:0] w_raw_target;

  assign o_pc_seq = i_pc + PC_INC;

  always_comb begin
    o_redirect   = 1'b0;
    w_raw_target = '0;
`ifdef PC_SEQ_EXC_EN
    if (i_exc) begin
      o_redirect   = 1'b1;
      w_raw_target = EXC_VECTOR;
    end else
`endif
    if (i_jmp) begin
      o_redirect   = 1'b1;
      w_raw_target = i_jmp_target;
    end else if (i_br_taken) begin
      o_redirect   = 1'b1;
      w_raw_target = i_br_target;
    end
    o_target = align_pc(w_raw_target);
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register, instruction-memory fetch handshake and one-deep IF/ID output slot.
// Define PC_SEQ_EXC_EN to add the exception redirect input and EPC capture.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef PC_SEQ_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_im_req,
  output logic [31:0] o_im_addr,
  input  logic        i_im_ack,
  input  logic [31:0] i_im_data,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_target,
`ifdef PC_SEQ_EXC_EN
  input  logic        i_exc,
  output logic [31:0] o_epc,
`endif
  output logic        o_unused_tie
);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_pc4, w_if_pc4_nxt;
  logic [31:0] w_pc_seq, w_target;
  logic        w_redirect, w_slot_busy;

  pc_next_mux
`ifdef PC_SEQ_EXC_EN
  #(
    .EXC_VECTOR (EXC_VECTOR)
  )
`endif
  u_next_mux (
    .i_pc         (r_pc),
    .i_br_taken   (i_br_taken),
    .i_br_target  (i_br_target),
    .i_jmp        (i_jmp),
    .i_jmp_target (i_jmp_target),
`ifdef PC_SEQ_EXC_EN
    .i_exc        (i_exc),
`endif
    .o_pc_seq     (w_pc_seq),
    .o_redirect   (w_redirect),
    .o_target     (w_target)
  );

  assign w_slot_busy = r_if_valid && i_stall;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_if_pc4_nxt   = r_if_pc4;
    case (r_state)
      StBoot: w_state_nxt = StFetch;
      StFetch: begin
        // Redirect discards any same-cycle ACK; a busy slot drops the request.
        if (w_redirect) begin
          w_pc_nxt       = w_target;
          w_if_valid_nxt = 1'b0;
        end else if (w_slot_busy) begin
          w_state_nxt = StHold;
        end else if (i_im_ack) begin
          w_if_instr_nxt = i_im_data;
          w_if_pc_nxt    = r_pc;
          w_if_pc4_nxt   = w_pc_seq;
          w_if_valid_nxt = 1'b1;
          w_pc_nxt       = w_pc_seq;
        end else if (r_if_valid) begin
          w_if_valid_nxt = 1'b0;
        end
      end
      StHold: begin
        if (w_redirect) begin
          w_pc_nxt       = w_target;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = StFetch;
        end else if (!i_stall) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = StFetch;
        end
      end
      default: w_state_nxt = StBoot;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StBoot;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_pc4   <= w_if_pc4_nxt;
    end
  end

`ifdef PC_SEQ_EXC_EN
  logic [31:0] r_epc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_epc <= '0;
    end else if (i_exc && (r_state != StBoot)) begin
      r_epc <= r_if_valid ? r_if_pc : r_pc;
    end
  end

  assign o_epc = r_epc;
`endif

  assign o_im_req     = (r_state == StFetch) && !w_slot_busy;
  assign o_im_addr    = r_pc;
  assign o_if_valid   = r_if_valid;
  assign o_if_instr   = r_if_instr;
  assign o_if_pc      = r_if_pc;
  assign o_if_pc4     = r_if_pc4;
  assign o_unused_tie = 1'b0;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Table-driven scoreboard bench for pc_fetch_sequencer; exception rows run when PC_SEQ_EXC_EN is defined.
module tb_pc_fetch_sequencer;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jmpt;
    logic        exc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, ack, stall, br, jmp;
  logic [31:0] data, brt, jmpt;
  logic        im_req, if_valid, tie0;
  logic [31:0] im_addr, if_instr, if_pc, if_pc4;

  logic        w_rst, w_ack, w_stall, w_br, w_jmp;
  logic [31:0] w_data, w_brt, w_jmpt;
  logic        w_im_req, w_if_valid, w_tie0;
  logic [31:0] w_im_addr, w_if_instr, w_if_pc, w_if_pc4;

`ifdef PC_SEQ_EXC_EN
  logic        exc, w_exc;
  logic [31:0] epc, w_epc;
`endif

  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_im_req     (im_req),
    .o_im_addr    (im_addr),
    .i_im_ack     (ack),
    .i_im_data    (data),
    .o_if_valid   (if_valid),
    .o_if_instr   (if_instr),
    .o_if_pc      (if_pc),
    .o_if_pc4     (if_pc4),
    .i_stall      (stall),
    .i_br_taken   (br),
    .i_br_target  (brt),
    .i_jmp        (jmp),
    .i_jmp_target (jmpt),
`ifdef PC_SEQ_EXC_EN
    .i_exc        (exc),
    .o_epc        (epc),
`endif
    .o_unused_tie (tie0)
  );

  pc_fetch_sequencer #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_w (
    .i_clk        (clk),
    .i_rst        (w_rst),
    .o_im_req     (w_im_req),
    .o_im_addr    (w_im_addr),
    .i_im_ack     (w_ack),
    .i_im_data    (w_data),
    .o_if_valid   (w_if_valid),
    .o_if_instr   (w_if_instr),
    .o_if_pc      (w_if_pc),
    .o_if_pc4     (w_if_pc4),
    .i_stall      (w_stall),
    .i_br_taken   (w_br),
    .i_br_target  (w_brt),
    .i_jmp        (w_jmp),
    .i_jmp_target (w_jmpt),
`ifdef PC_SEQ_EXC_EN
    .i_exc        (w_exc),
    .o_epc        (w_epc),
`endif
    .o_unused_tie (w_tie0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic r, input logic a, input logic s, input logic b,
                              input logic [31:0] bt, input logic j, input logic [31:0] jt,
                              input logic e, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.ack = a; v.stall = s; v.br = b; v.brt = bt; v.jmp = j; v.jmpt = jt;
    v.exc = e; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  // Drive one cycle, check the live request, then score the registered outputs after the edge.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; ack = v.ack; stall = v.stall; br = v.br; brt = v.brt;
    jmp = v.jmp; jmpt = v.jmpt; data = 32'hA000_0000 | v.exp_addr;
`ifdef PC_SEQ_EXC_EN
    exc = v.exc;
`endif
    #1;
    chk($sformatf("v%0d im_req", idx), {31'b0, im_req}, {31'b0, v.exp_req});
    chk($sformatf("v%0d im_addr", idx), im_addr, v.exp_addr);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d if_valid", idx), {31'b0, if_valid}, {31'b0, e.exp_valid});
    if (e.rst) begin
      chk($sformatf("v%0d rst im_req", idx), {31'b0, im_req}, 32'd0);
      chk($sformatf("v%0d rst im_addr", idx), im_addr, 32'h0);
      chk($sformatf("v%0d rst if_instr", idx), if_instr, 32'h0);
      chk($sformatf("v%0d rst if_pc", idx), if_pc, 32'h0);
      chk($sformatf("v%0d rst if_pc4", idx), if_pc4, 32'h0);
`ifdef PC_SEQ_EXC_EN
      chk($sformatf("v%0d rst epc", idx), epc, 32'h0);
`endif
    end else if (e.exp_valid) begin
      chk($sformatf("v%0d if_pc", idx), if_pc, e.exp_pc);
      chk($sformatf("v%0d if_pc4", idx), if_pc4, e.exp_pc + 32'd4);
      chk($sformatf("v%0d if_instr", idx), if_instr, 32'hA000_0000 | e.exp_pc);
    end
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0;
    data = '0; brt = '0; jmpt = '0;
    w_rst = 1'b1; w_ack = 1'b1; w_stall = 1'b0; w_br = 1'b0; w_jmp = 1'b0;
    w_data = 32'h1234_5678; w_brt = '0; w_jmpt = '0;
`ifdef PC_SEQ_EXC_EN
    exc = 1'b0; w_exc = 1'b0;
`endif

    //          rst ack stl br brt           jmp jmpt          exc req addr          vld pc
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0000, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0004, 1, 32'h4));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0008, 1, 32'h8));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0000_000C, 1, 32'h8));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0000_000C, 1, 32'h8));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0000_000C, 1, 32'h8));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0000_000C, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_000C, 1, 32'hC));
    vecs.push_back(mk(0, 1, 0, 1, 32'h100,   1, 32'h200,   0, 1, 32'h0000_0010, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0200, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0200, 1, 32'h200));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0204, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h103,   0, 32'h0,     0, 1, 32'h0000_0204, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0100, 1, 32'h100));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0000_0104, 1, 32'h100));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,     1, 32'h300,   0, 0, 32'h0000_0104, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0300, 1, 32'h300));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0304, 1, 32'h304));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0308, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0000, 1, 32'h0));
`ifdef PC_SEQ_EXC_EN
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     1, 32'h40,    0, 1, 32'h0000_0004, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0040, 1, 32'h40));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     1, 32'h200,   1, 1, 32'h0000_0044, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h0000_0080, 1, 32'h80));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset im_req", {31'b0, im_req}, 32'd0);
    chk("reset im_addr", im_addr, 32'h0);
    chk("reset if_valid", {31'b0, if_valid}, 32'd0);
    chk("reset if_instr", if_instr, 32'h0);
    chk("reset if_pc", if_pc, 32'h0);
    chk("reset if_pc4", if_pc4, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i], i);

`ifdef PC_SEQ_EXC_EN
    chk("epc after exc", epc, 32'h40);
`endif

    // Wrap-around instance: fetch continues through 0xFFFF_FFFC into 0.
    @(negedge clk);
    w_rst = 1'b0;
    #1;
    chk("wrap boot im_req", {31'b0, w_im_req}, 32'd0);
    chk("wrap boot im_addr", w_im_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    #1;
    chk("wrap im_addr0", w_im_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    #1;
    chk("wrap im_addr1", w_im_addr, 32'hFFFF_FFFC);
    chk("wrap if_pc", w_if_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    #1;
    chk("wrap im_addr2", w_im_addr, 32'h0000_0000);
    chk("wrap if_pc4", w_if_pc4, 32'h0000_0000);
    w_br = 1'b1;
    w_brt = 32'h0000_0103;
    @(negedge clk);
    w_br = 1'b0;
    #1;
    chk("wrap aligned target", w_im_addr, 32'h0000_0100);
    chk("wrap flush", {31'b0, w_if_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
